// File: rtl/spi_master_pkg.sv
// Shared constants for the dual-device SPI master.
// State codes, device indices and default sizing.
package spi_master_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_SHIFT_LO = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  localparam int DEV_ADF4002 = 0;
  localparam int DEV_LMX2594 = 1;

  localparam int DEF_MAX_BITS = 24;
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CS_GAP   = 1;

  function automatic logic [7:0] clamp_depth(
    input logic [7:0] d,
    input logic [7:0] max_bits
  );
    return (d > max_bits) ? max_bits : d;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator for the SPI master.
// Emits a one-cycle tick every CLK_DIV cycles while not cleared.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/spi_master_dual.sv
// Shared-bus SPI master for the ADF4002 (cs 0) and LMX2594 (cs 1).
// Mode 0, MSB-first, optional MISO capture.
module spi_master_dual
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CS_GAP   = DEF_CS_GAP,
  parameter int MAX_BITS = DEF_MAX_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          spi_start,
  input  logic                spi_dir,
  input  logic [MAX_BITS-1:0] spi_data_tx,
  input  logic [7:0]          spi_data_depth,
  output logic [1:0]          spi_ready,
  output logic [MAX_BITS-1:0] spi_data_rx,
  output logic                rx_valid,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic [1:0]          cs_n
);

  localparam logic [7:0] MAX8 = 8'(MAX_BITS);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  logic [2:0]          state;
  logic [7:0]          bit_cnt;
  logic [MAX_BITS-1:0] tx_sr;
  logic [MAX_BITS-1:0] rx_sr;
  logic                dir_q;
  logic                zero_q;
  logic [GW-1:0]       gap_cnt;
  logic                tick;

  logic                accept;
  logic [7:0]          n_eff;
  logic [1:0]          cs_drop;
  logic [MAX_BITS-1:0] tx_aligned;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_IDLE),
    .tick  (tick)
  );

  // Frame is left-aligned so the next bit is always the top bit.
  always_comb begin
    accept     = (state == ST_IDLE) && (spi_start != 2'b00);
    n_eff      = clamp_depth(spi_data_depth, MAX8);
    tx_aligned = spi_data_tx << (MAX8 - n_eff);
    cs_drop    = spi_start[DEV_ADF4002] ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      spi_ready   <= 2'b00;
      cs_n        <= 2'b11;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      rx_valid    <= 1'b0;
      spi_data_rx <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      dir_q       <= 1'b0;
      zero_q      <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            spi_ready <= 2'b00;
            dir_q     <= spi_dir;
            gap_cnt   <= '0;
            if (n_eff == 8'd0) begin
              zero_q <= 1'b1;
              state  <= ST_GAP;
            end else begin
              zero_q  <= 1'b0;
              cs_n    <= cs_drop;
              tx_sr   <= tx_aligned;
              mosi    <= tx_aligned[MAX_BITS-1];
              bit_cnt <= n_eff;
              rx_sr   <= '0;
              state   <= ST_SETUP;
            end
          end else begin
            spi_ready <= 2'b11;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            state <= ST_SHIFT_HI;
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[MAX_BITS-2:0], miso};
          end
        end
        ST_SHIFT_HI: begin
          if (tick) begin
            state   <= ST_SHIFT_LO;
            sclk    <= 1'b0;
            bit_cnt <= 8'(bit_cnt - 8'd1);
            if (bit_cnt != 8'd1) begin
              tx_sr <= tx_sr << 1;
              mosi  <= tx_sr[MAX_BITS-2];
            end
          end
        end
        ST_SHIFT_LO: begin
          if (tick) begin
            if (bit_cnt != 8'd0) begin
              state <= ST_SHIFT_HI;
              sclk  <= 1'b1;
              rx_sr <= {rx_sr[MAX_BITS-2:0], miso};
            end else begin
              state <= ST_HOLD;
              mosi  <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            cs_n    <= 2'b11;
            state   <= ST_GAP;
            gap_cnt <= '0;
            if (dir_q) begin
              spi_data_rx <= rx_sr;
              rx_valid    <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          // An empty frame only spends one cycle here.
          if (zero_q) begin
            zero_q    <= 1'b0;
            state     <= ST_IDLE;
            spi_ready <= 2'b11;
          end else if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              state     <= ST_IDLE;
              spi_ready <= 2'b11;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_dual.sv
// Directed bench for spi_master_dual.
// Frame timing, MOSI order, MISO capture, arbitration, reset abort.
module tb_spi_master_dual;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  spi_start = 2'b00;
  logic        spi_dir = 1'b0;
  logic [23:0] spi_data_tx = '0;
  logic [7:0]  spi_data_depth = '0;
  logic [1:0]  spi_ready;
  logic [23:0] spi_data_rx;
  logic        rx_valid;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [1:0]  cs_n;

  spi_master_dual dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .spi_start      (spi_start),
    .spi_dir        (spi_dir),
    .spi_data_tx    (spi_data_tx),
    .spi_data_depth (spi_data_depth),
    .spi_ready      (spi_ready),
    .spi_data_rx    (spi_data_rx),
    .rx_valid       (rx_valid),
    .sclk           (sclk),
    .mosi           (mosi),
    .miso           (miso),
    .cs_n           (cs_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int           rises = 0;
  int           rxv = 0;
  logic [127:0] mlog = '0;
  logic [1:0]   rxv_cs = 2'b00;
  logic         sclk_q = 1'b0;

  always @(negedge clk) begin
    if (sclk && !sclk_q) begin
      rises = rises + 1;
      mlog  = {mlog[126:0], mosi};
    end
    sclk_q = sclk;
    if (rx_valid) begin
      rxv    = rxv + 1;
      rxv_cs = cs_n;
    end
  end

  // LMX2594 readback model: bit k of the frame is driven before SCLK rise k.
  logic [23:0] pat = '0;
  int          base = 0;
  int          midx;

  always_comb begin
    midx = rises - base;
    miso = 1'b0;
    if (!cs_n[1] && midx >= 0 && midx < 24)
      miso = pat[23-midx];
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (spi_ready != 2'b11 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("ready_timeout", spi_ready, 2'b11);
  endtask

  task automatic frame(input logic [1:0] st, input logic [23:0] tx,
                       input logic [7:0] dep, input logic d,
                       input logic [1:0] st_after, output int low,
                       output logic [1:0] cs_seen);
    wait_ready();
    spi_start      = st;
    spi_data_tx    = tx;
    spi_data_depth = dep;
    spi_dir        = d;
    @(negedge clk);
    spi_start = st_after;
    cs_seen   = cs_n;
    low       = 0;
    while (spi_ready != 2'b11 && low < 5000) begin
      low++;
      @(negedge clk);
    end
    if (low >= 5000) check("frame_timeout", spi_ready, 2'b11);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          low, r0, v0, n;
    logic [1:0]  cs;
    logic [23:0] w [4];
    w[0] = 24'h123456;
    w[1] = 24'hABCDEF;
    w[2] = 24'h0F0F0F;
    w[3] = 24'h800001;

    repeat (3) @(negedge clk);
    check("rst_ready", spi_ready, 2'b00);
    check("rst_cs", cs_n, 2'b11);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_rxv", rx_valid, 1'b0);
    check("rst_rx", spi_data_rx, 24'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", spi_ready, 2'b11);

    // Single write to ADF4002
    r0 = rises; v0 = rxv;
    frame(2'b01, 24'h1F8093, 8'd24, 1'b0, 2'b00, low, cs);
    check("t1_cs", cs, 2'b10);
    check("t1_low", low, 204);
    check("t1_rises", rises - r0, 24);
    check("t1_mosi", mlog[23:0], 24'h1F8093);
    check("t1_no_rxv", rxv - v0, 0);

    // Back-to-back stream with start held
    r0 = rises;
    wait_ready();
    spi_start = 2'b01; spi_dir = 1'b0;
    spi_data_depth = 8'd24; spi_data_tx = w[0];
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      n = 0;
      while (spi_ready != 2'b11 && n < 5000) begin
        n++;
        @(negedge clk);
      end
      check("t2_low", n, 204);
      spi_data_tx = w[i];
    end
    @(negedge clk);
    spi_start = 2'b00;
    wait_ready();
    repeat (5) @(negedge clk);
    check("t2_idle", spi_ready, 2'b11);
    check("t2_rises", rises - r0, 96);
    check("t2_mosi", mlog[95:0], {w[0], w[1], w[2], w[3]});

    // LMX2594 readback
    pat = 24'hA5C33C; base = rises; v0 = rxv;
    frame(2'b10, 24'h5A5A5A, 8'd24, 1'b1, 2'b00, low, cs);
    check("t3_cs", cs, 2'b01);
    check("t3_low", low, 204);
    check("t3_rxv", rxv - v0, 1);
    check("t3_rx", spi_data_rx, 24'hA5C33C);
    check("t3_rxv_cs", rxv_cs, 2'b11);

    // Both requested: device 0 first, device 1 next
    r0 = rises;
    frame(2'b11, 24'h00F00F, 8'd24, 1'b0, 2'b10, low, cs);
    check("t4_first_cs", cs, 2'b10);
    check("t4_low", low, 204);
    @(negedge clk);
    spi_start = 2'b00;
    check("t4_second_cs", cs_n, 2'b01);
    check("t4_second_rdy", spi_ready, 2'b00);
    wait_ready();
    check("t4_rises", rises - r0, 48);

    // Empty frame, then over-long depth
    r0 = rises; v0 = rxv;
    frame(2'b01, 24'hFFFFFF, 8'd0, 1'b1, 2'b00, low, cs);
    check("t5_zero_cs", cs, 2'b11);
    check("t5_zero_low", low, 1);
    check("t5_zero_rises", rises - r0, 0);
    check("t5_zero_rxv", rxv - v0, 0);
    r0 = rises;
    frame(2'b01, 24'hC3A5F0, 8'd40, 1'b0, 2'b00, low, cs);
    check("t5_40_low", low, 204);
    check("t5_40_rises", rises - r0, 24);
    check("t5_40_mosi", mlog[23:0], 24'hC3A5F0);

    // Reset mid-frame
    r0 = rises; v0 = rxv;
    wait_ready();
    spi_start = 2'b10; spi_dir = 1'b1;
    spi_data_depth = 8'd24; spi_data_tx = 24'h777777;
    @(negedge clk);
    spi_start = 2'b00;
    n = 0;
    while (rises - r0 < 10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_bit10", rises - r0, 10);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_cs", cs_n, 2'b11);
    check("t6_sclk", sclk, 1'b0);
    check("t6_ready", spi_ready, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_rxv", rxv - v0, 0);
    check("t6_rx", spi_data_rx, 24'h0);
    r0 = rises;
    frame(2'b01, 24'h2468AC, 8'd24, 1'b0, 2'b00, low, cs);
    check("t6_after_cs", cs, 2'b10);
    check("t6_after_low", low, 204);
    check("t6_after_rises", rises - r0, 24);
    check("t6_after_mosi", mlog[23:0], 24'h2468AC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_dual.md
Name: spi_master_dual

Overview:
- Single shared-bus SPI master that consumes the control block's SPI request interface (`spi_start`, `spi_dir`, `spi_data_tx`, `spi_data_depth`) and returns `spi_ready`.
- Drives the ADF4002 (chip-select 0, LE) and the LMX2594 (chip-select 1, CSB) over a common SCLK/MOSI.
- Captures MISO (LMX2594 MUXout readback) when a read is requested.
- Sits directly downstream of the register-init/UART-debug controller.

Parameters:
- CLK_DIV, 4: `clk` cycles per SCLK half-period; minimum 1.
- CS_GAP, 1: half-periods with chip-select high before `spi_ready` returns; minimum 1.
- MAX_BITS, 24: maximum frame length and data width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- spi_start  in  2  level request; bit k selects device k
- spi_dir  in  1  0 = write only, 1 = write and capture MISO
- spi_data_tx  in  MAX_BITS  frame, right-aligned, sent MSB-first from bit depth-1
- spi_data_depth  in  8  bits per frame
- spi_ready  out  2  both bits = bus idle and able to accept
- spi_data_rx  out  MAX_BITS  captured MISO bits, right-aligned
- rx_valid  out  1  one-cycle pulse when `spi_data_rx` updates
- sclk  out  1  SPI clock, mode 0
- mosi  out  1  serial data out
- miso  in  1  serial data in
- cs_n  out  2  active-low chip selects; rising edge latches (ADF4002 LE, LMX2594 CSB)

Behaviour:
- Reset is synchronous, active-low, on `rst_n`; clock is `clk`.
- While `rst_n`=0, at any point including mid-frame:
  - `spi_ready`=00, `cs_n`=11, `sclk`=0, `mosi`=0, `rx_valid`=0, `spi_data_rx`=0, state=IDLE.
  - An aborted frame is discarded, no `rx_valid`.
- `spi_ready`=11 from the first cycle after `rst_n`=1.
- Acceptance happens on any edge where state=IDLE and `spi_start`!=0.
  - `spi_data_tx`, `spi_data_depth`, `spi_dir` and the device index are latched at that edge.
  - `spi_ready` goes 00 at that same edge.
  - Acceptance does not wait for a `spi_start` rising edge: `spi_start` is a level. The requester holds it high and updates data on every cycle it sees ready=1, so each ready-high cycle consumes exactly one frame.
- When both `spi_start` bits are set, device 0 wins. Device 1 stays pending and is served at the next IDLE.
- Depth rules:
  - Effective N = depth clamped to MAX_BITS.
  - depth=0: no frame, `cs_n` stays high, ready returns after one cycle in GAP, no `rx_valid`.
- State machine (a half-period tick fires every CLK_DIV clk cycles; the counter restarts at acceptance):
  - IDLE: ready=11. Transition on accept to SETUP; drop the selected `cs_n`, `mosi` = bit N-1.
  - SETUP: one half-period, `sclk` low, then SHIFT_HI.
  - SHIFT_HI: `sclk`=1; sample `miso` into the rx shift register at entry; one half-period, then SHIFT_LO.
  - SHIFT_LO: `sclk`=0; decrement the bit count. If bits remain, shift `mosi` to the next bit and return to SHIFT_HI after one half-period. Otherwise go to HOLD.
  - HOLD: one half-period with `cs_n` still low and `sclk` low; `mosi`=0. On exit raise `cs_n`; if dir=1, load `spi_data_rx` and pulse `rx_valid`.
  - GAP: CS_GAP half-periods with `cs_n` high, then IDLE.
- Latency: `spi_ready` stays low for exactly (2N+2+CS_GAP)*CLK_DIV cycles after the accept edge. Defaults with N=24 give 204 cycles.
- `sclk` has exactly N rising edges per frame. Only the selected `cs_n` ever goes low.
- `spi_start`, data and depth changes during a frame are ignored.
- `spi_data_rx` bits above N are zero.

Decomposition:
- Package spi_master_pkg: state enum (IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP), DEV_ADF4002=0, DEV_LMX2594=1, default MAX_BITS/CLK_DIV.
- Sub-module spi_tick_gen: CLK_DIV half-period counter with synchronous clear, one-cycle tick output.

Test Plan:
- Reset release, `spi_start`=01 with `spi_data_tx`=24'h1F8093, depth=24, dir=0 → `cs_n`=10; 24 SCLK rising edges; MOSI sequence 0001_1111_1000_0000_1001_0011; ready low for 204 cycles; no `rx_valid`.
- Hold `spi_start`=01 and advance data on every ready-high cycle through 4 words → exactly 4 frames, each word once, in order, ready high exactly one cycle between frames.
- `spi_start`=10, dir=1, depth=24, MISO model returns 24'hA5C33C → `cs_n`=01; `rx_valid` pulses once at the `cs_n` rising edge; `spi_data_rx`=24'hA5C33C.
- `spi_start`=11 → device 0 frame first; device 1 frame starts on the next ready-high cycle.
- depth=0 → no SCLK, `cs_n` stays 11, ready back after 1 cycle. depth=40 → 24 bits sent.
- `rst_n` pulled low at bit 10 of a frame → next cycle `cs_n`=11, `sclk`=0, ready=00; after release a new frame completes normally.
